// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider sequencer for DIV/DIVU.
// Retires one quotient bit per cycle over WIDTH cycles. It stalls the pipeline
// while running and strobes the quotient (LO) and remainder (HI) for one cycle.
// Optional build macro DIV_ZERO_FASTPATH_EN: a divide by zero skips the
// iterations and goes straight to DONE.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvnd_q, dvnd_d;      // dividend magnitude; quotient bits shift in at the bottom
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;      // divisor magnitude
    logic [WIDTH-1:0]   prem_q, prem_d;      // partial remainder
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;

    logic               stall_c;
    logic               busy_c;
    logic               valid_c;

    logic               dividend_neg;
    logic               divisor_neg;
    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [WIDTH-1:0]   prem_next;
    logic [WIDTH-1:0]   dvnd_next;

    // Two's-complement negate when n is set.
    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    // Operand signs and magnitudes; unsigned requests are taken raw.
    always_comb begin
        dividend_neg = signed_i & dividend_i[WIDTH-1];
        divisor_neg  = signed_i & divisor_i[WIDTH-1];
        dividend_mag = neg_if(dividend_neg, dividend_i);
        divisor_mag  = neg_if(divisor_neg, divisor_i);
    end

    // One restoring step: shift, trial-subtract in WIDTH+1 bits, keep or restore.
    always_comb begin
        shifted   = {prem_q, dvnd_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvsr_q};
        qbit      = ~trial[WIDTH];
        prem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvnd_next = {dvnd_q[WIDTH-2:0], qbit};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvnd_d      = dvnd_q;
        dvsr_d      = dvsr_q;
        prem_d      = prem_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        stall_c     = 1'b0;
        busy_c      = (state_q != IDLE);
        valid_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    stall_c = 1'b1;
                    dvnd_d  = dividend_mag;
                    dvsr_d  = divisor_mag;
                    prem_d  = '0;
                    cnt_d   = '0;
                    qneg_d  = dividend_neg ^ divisor_neg;
                    rneg_d  = dividend_neg;
`ifdef DIV_ZERO_FASTPATH_EN
                    if (divisor_i == '0) begin
                        // Same result the full iteration would produce: all-ones quotient, dividend remainder.
                        state_d     = DONE;
                        quotient_d  = neg_if(dividend_neg ^ divisor_neg, '1);
                        remainder_d = neg_if(dividend_neg, dividend_mag);
                    end else begin
                        state_d = BUSY;
                    end
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    dvnd_d = dvnd_next;
                    prem_d = prem_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d     = DONE;
                        quotient_d  = neg_if(qneg_q, dvnd_next);
                        remainder_d = neg_if(rneg_q, prem_next);
                    end
                end
            end
            DONE: begin
                valid_c = ~flush_i;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q       <= '0;
            dvnd_q      <= '0;
            dvsr_q      <= '0;
            prem_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            dvnd_q      <= dvnd_d;
            dvsr_q      <= dvsr_d;
            prem_q      <= prem_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Stall and strobe must react within the request/flush cycle, so they are decoded from state.
    assign stall_o     = stall_c;
    assign busy_o      = busy_c;
    assign valid_o     = valid_c;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Testbench for div_sequencer: directed divides checked every cycle against a
// cycle-schedule model plus plain-arithmetic results, and pinned by literals.
module tb_div_sequencer;

    localparam int unsigned W = 32;
`ifdef DIV_ZERO_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk;
    logic         resetn;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         flush_i;
    logic         stall_o;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;

    div_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Request bookkeeping, written only by the driver.
    bit           act = 1'b0;
    int           req_cyc = 0;
    int           lat = 0;
    int           abort_cyc = 0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    bit           lit_en = 1'b0;
    logic [W-1:0] lit_q = '0;
    logic [W-1:0] lit_r = '0;

    // Result expected at DONE, from ordinary integer division on magnitudes.
    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic         an, bn;
        logic [W-1:0] am, bm, qm, rm, q, r;
        an = s & a[W-1];
        bn = s & b[W-1];
        am = an ? -a : a;
        bm = bn ? -b : b;
        if (bm == '0) begin
            qm = '1;
            rm = am;
        end else begin
            qm = am / bm;
            rm = am % bm;
        end
        q = (an ^ bn) ? -qm : qm;
        r = an ? -rm : rm;
        return {q, r};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Compare process: model pins first, then every cycle after reset.
    initial begin
        logic [W-1:0] pq, pr;
        logic [W-1:0] held_q, held_r;
        bit in_busy, in_done, idle_e, stall_e, valid_e;
        held_q = '0;
        held_r = '0;

        {pq, pr} = model(1'b0, 32'd100, 32'd7);
        chk("pin_q_100_7", pq, 32'd14);
        chk("pin_r_100_7", pr, 32'd2);
        {pq, pr} = model(1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("pin_q_m7_2", pq, 32'hFFFF_FFFD);
        chk("pin_r_m7_2", pr, 32'hFFFF_FFFF);
        {pq, pr} = model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("pin_q_ovf", pq, 32'h8000_0000);
        chk("pin_r_ovf", pr, 32'h0);
        {pq, pr} = model(1'b1, 32'hFFFF_FFFB, 32'h0);
        chk("pin_q_sdiv0", pq, 32'h1);
        chk("pin_r_sdiv0", pr, 32'hFFFF_FFFB);

        repeat (2) @(negedge clk);
        forever begin
            @(negedge clk);
            in_busy = act && (cyc > req_cyc) && (cyc <= req_cyc + lat) && (cyc <= abort_cyc);
            in_done = act && (cyc == req_cyc + lat + 1) && (cyc <= abort_cyc);
            idle_e  = !(in_busy || in_done);
            stall_e = in_busy || (idle_e && start_i && !flush_i);
            valid_e = in_done && !flush_i;
            if (in_done) begin
                held_q = m_q;
                held_r = m_r;
            end
            chk("busy_o", W'(busy_o), W'(!idle_e));
            chk("stall_o", W'(stall_o), W'(stall_e));
            chk("valid_o", W'(valid_o), W'(valid_e));
            chk("quotient_o", quotient_o, held_q);
            chk("remainder_o", remainder_o, held_r);
            if (in_done && lit_en) begin
                chk("lit_valid", W'(valid_o), W'(1));
                chk("lit_quotient", quotient_o, lit_q);
                chk("lit_remainder", remainder_o, lit_r);
            end
            if (!resetn) begin
                held_q = '0;
                held_r = '0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit lit, input logic [W-1:0] lq, input logic [W-1:0] lr);
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        flush_i    = 1'b0;
        req_cyc    = cyc;
        lat        = (FAST && b == '0) ? 0 : int'(W);
        abort_cyc  = 1 << 30;
        {m_q, m_r} = model(s, a, b);
        lit_en     = lit;
        lit_q      = lq;
        lit_r      = lr;
        act        = 1'b1;
        tick();
        start_i    = 1'b0;
        signed_i   = 1'($urandom);
        dividend_i = $urandom;
        divisor_i  = $urandom;
    endtask

    task automatic wait_done;
        while (cyc <= req_cyc + lat + 1) tick();
    endtask

    // Directed stimulus.
    initial begin
        resetn     = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        flush_i    = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (2) tick();

        issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
        wait_done();
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        wait_done();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        wait_done();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0);
        wait_done();
        issue(1'b0, 32'h1234_5678, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        wait_done();
        issue(1'b1, 32'hFFFF_FFFB, 32'h0, 1'b1, 32'h1, 32'hFFFF_FFFB);
        wait_done();

        // Flush in BUSY, then a fresh divide in the following cycle.
        issue(1'b0, 32'd1000, 32'd3, 1'b0, '0, '0);
        while (cyc < req_cyc + 10) tick();
        flush_i   = 1'b1;
        abort_cyc = cyc;
        tick();
        flush_i = 1'b0;
        issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0);
        wait_done();

        // start_i pulses with other operands while BUSY must not disturb the result.
        issue(1'b1, 32'hFFFF_FC18, 32'd7, 1'b1, 32'hFFFF_FF72, 32'hFFFF_FFFA);
        for (int k = 0; k < 6; k++) begin
            start_i    = 1'(k % 2);
            dividend_i = $urandom;
            divisor_i  = $urandom;
            tick();
        end
        start_i = 1'b0;
        wait_done();

        // Flush during DONE: results land in the outputs but no strobe.
        issue(1'b0, 32'd50, 32'd5, 1'b0, '0, '0);
        while (cyc < req_cyc + lat + 1) tick();
        flush_i   = 1'b1;
        abort_cyc = cyc;
        tick();
        flush_i = 1'b0;
        tick();

        // Reset in the middle of a divide.
        issue(1'b0, 32'hDEAD_BEEF, 32'h1234, 1'b0, '0, '0);
        while (cyc < req_cyc + 20) tick();
        resetn    = 1'b0;
        abort_cyc = cyc;
        tick();
        resetn = 1'b1;
        repeat (2) tick();

        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0);
        wait_done();
        issue(1'b0, 32'd5, 32'd9, 1'b1, 32'd0, 32'd5);
        wait_done();

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
